// File: rtl/uart_pkg.sv
// Shared types for the UART datapath: feeder FSM encoding, queued transmit
// entry layout and a byte-extract helper used when loading sdata.
package uart_pkg;

  localparam int UART_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } feeder_state_e;

  typedef struct packed {
    logic [1:0]  len;
    logic [31:0] data;
  } tx_entry_t;

  localparam int TX_ENTRY_W = $bits(tx_entry_t);

  // Lowest byte of a word; bytes leave the feeder LSB first.
  function automatic logic [7:0] low_byte(input logic [31:0] word);
    return word[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// sync_fifo: single-clock FIFO with (DEPTH_LOG2+1)-bit wrap pointers.
// empty when pointers match, full when only the wrap bit differs.
// Pushes while full and pops while empty are ignored. Read data is
// presented combinationally from the read pointer (show-ahead).
module sync_fifo #(
  parameter int WIDTH      = 34,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    r_mem [0:DEPTH-1];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_full;
  logic                w_empty;
  logic                w_do_push;
  logic                w_do_pop;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  // A push is judged against the current full flag only, so a push that
  // coincides with a pop on a full FIFO is still dropped.
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_data  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  // Pointer update; both pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + (DEPTH_LOG2+1)'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + (DEPTH_LOG2+1)'(1);
      end
    end
  end

  // Storage write; contents need no reset since empty masks stale data.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: queues {len, word} entries and hands them to the UART
// transmitter one byte at a time, LSB first, pacing on tx_busy.
// Optional build macro UART_TX_FEEDER_OVF_CNT_EN adds ovf_cnt/ovf_clr, a
// saturating count of pushes dropped because the FIFO was full.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_len,
  output logic              full,
  output logic              idle,
  output logic [7:0]        sdata,
  output logic              tx_start,
`ifdef UART_TX_FEEDER_OVF_CNT_EN
  input  logic              ovf_clr,
  output logic [15:0]       ovf_cnt,
`endif
  input  logic              tx_busy
);

  tx_entry_t     w_wr_entry;
  tx_entry_t     w_rd_entry;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;

  feeder_state_e r_state;
  feeder_state_e w_state_nxt;
  logic [31:0]   r_shift;
  logic [31:0]   w_shift_nxt;
  logic [1:0]    r_remaining;
  logic [1:0]    w_remaining_nxt;
  logic [7:0]    r_sdata;
  logic [7:0]    w_sdata_nxt;
  logic          r_tx_start;
  logic          w_tx_start_nxt;

  assign w_wr_entry.len  = wr_len;
  assign w_wr_entry.data = wr_data;

  sync_fifo #(
    .WIDTH      (TX_ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (wr_en),
    .i_data  (w_wr_entry),
    .i_pop   (w_pop),
    .o_data  (w_rd_entry),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign full     = w_full;
  assign idle     = w_empty && (r_state == S_IDLE);
  assign sdata    = r_sdata;
  assign tx_start = r_tx_start;

  // Feeder state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_shift     <= 32'h0000_0000;
      r_remaining <= 2'd0;
      r_sdata     <= 8'h00;
      r_tx_start  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_remaining <= w_remaining_nxt;
      r_sdata     <= w_sdata_nxt;
      r_tx_start  <= w_tx_start_nxt;
    end
  end

  // Next-state logic. tx_start defaults low so it is a single-cycle pulse;
  // S_ACK absorbs the cycle before the transmitter raises tx_busy.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_remaining_nxt = r_remaining;
    w_sdata_nxt     = r_sdata;
    w_tx_start_nxt  = 1'b0;
    w_pop           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_shift_nxt     = w_rd_entry.data;
          w_remaining_nxt = w_rd_entry.len;
          w_pop           = 1'b1;
          w_state_nxt     = S_SEND;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_sdata_nxt    = low_byte(r_shift);
          w_state_nxt    = S_ACK;
        end else begin
          w_state_nxt = S_SEND;
        end
      end
      S_ACK: begin
        if (tx_busy) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ACK;
        end
      end
      S_DONE: begin
        if (!tx_busy) begin
          if (r_remaining == 2'd0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_shift_nxt     = {8'h00, r_shift[31:8]};
            w_remaining_nxt = r_remaining - 2'd1;
            w_state_nxt     = S_SEND;
          end
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef UART_TX_FEEDER_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;
  logic        w_drop;

  assign w_drop  = wr_en && w_full;
  assign ovf_cnt = r_ovf_cnt;

  // Dropped-push counter; clear wins over a simultaneous drop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ovf_cnt <= 16'h0000;
    end else if (ovf_clr) begin
      r_ovf_cnt <= 16'h0000;
    end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a behavioural transmitter
// (CLK_PER_HALF_BIT=4, 10-bit frame). Expected bytes are queued at push
// time and popped when the DUT pulses tx_start.
module tb_uart_tx_feeder;

  localparam int DEPTH_LOG2       = 4;
  localparam int CLK_PER_HALF_BIT = 4;
  localparam int FRAME_CYC        = 2 * CLK_PER_HALF_BIT * 10;

  logic        clk     = 1'b0;
  logic        rstn    = 1'b0;
  logic        wr_en   = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic [1:0]  wr_len  = 2'd0;
  logic        full;
  logic        idle;
  logic [7:0]  sdata;
  logic        tx_start;
  logic        tx_busy;
  logic        stall   = 1'b0;
  logic        m_busy;
  int          m_cnt;
`ifdef UART_TX_FEEDER_OVF_CNT_EN
  logic        ovf_clr = 1'b0;
  logic [15:0] ovf_cnt;
`endif

  int          n_vec   = 0;
  int          n_miss  = 0;
  int          n_pulse = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  assign tx_busy = m_busy | stall;

  uart_tx_feeder #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_len   (wr_len),
    .full     (full),
    .idle     (idle),
    .sdata    (sdata),
    .tx_start (tx_start),
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    .ovf_clr  (ovf_clr),
    .ovf_cnt  (ovf_cnt),
`endif
    .tx_busy  (tx_busy)
  );

  // Transmitter model: busy from the cycle after an accepted start for one frame.
  always @(posedge clk) begin
    if (!rstn) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (m_cnt == 1) m_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end else if (tx_start) begin
      m_busy <= 1'b1;
      m_cnt  <= FRAME_CYC;
    end
  end

  task automatic monitor();
    logic       prev = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        n_pulse++;
        n_vec++;
        if (tx_busy !== 1'b0 || prev !== 1'b0) begin
          n_miss++;
          $display("FAIL start_spacing: tx_busy=%b prev_start=%b, required 0/0", tx_busy, prev);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_byte: sdata=%h, required no tx_start", sdata);
        end else begin
          e = exp_q.pop_front();
          if (sdata !== e) begin
            n_miss++;
            $display("FAIL byte_order: sdata=%h, required %h", sdata, e);
          end
        end
      end
      prev = tx_start;
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic [1:0] l, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    wr_len  = l;
    if (accept) begin
      for (int i = 0; i <= int'(l); i++) exp_q.push_back(d[8*i +: 8]);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (idle === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_vec++;
      if (idle !== 1'b1 || full !== 1'b0 || tx_start !== 1'b0 || sdata !== 8'h00) begin
        n_miss++;
        $display("FAIL reset_state: idle=%b full=%b tx_start=%b sdata=%h, required 1 0 0 00",
                 idle, full, tx_start, sdata);
      end
    end
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    n_vec++;
    if (ovf_cnt !== 16'h0000) begin
      n_miss++;
      $display("FAIL reset_ovf: ovf_cnt=%h, required 0000", ovf_cnt);
    end
`endif
  endtask

  task automatic test_single_word();
    int base = n_pulse;
    bit ok;
    push_word(32'hDDCC_BBAA, 2'd3, 1'b1);
    wr_en = 1'b0;
    n_vec++;
    if (idle !== 1'b0 || tx_start !== 1'b0) begin
      n_miss++;
      $display("FAIL latency_n: idle=%b tx_start=%b, required 0 0", idle, tx_start);
    end
    @(negedge clk);
    n_vec++;
    if (tx_start !== 1'b0) begin
      n_miss++;
      $display("FAIL latency_n1: tx_start=%b, required 0", tx_start);
    end
    @(negedge clk);
    n_vec++;
    if (tx_start !== 1'b1 || sdata !== 8'hAA) begin
      n_miss++;
      $display("FAIL latency_n2: tx_start=%b sdata=%h, required 1 AA", tx_start, sdata);
    end
    wait_idle(600, ok);
    n_vec++;
    if (!ok || tx_busy !== 1'b0) begin
      n_miss++;
      $display("FAIL single_idle: idle=%b tx_busy=%b, required 1 0", idle, tx_busy);
    end
    n_vec++;
    if (n_pulse - base != 4 || exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL single_pulses: pulses=%0d left=%0d, required 4 0", n_pulse - base, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int base = n_pulse;
    bit ok;
    push_word(32'h0000_0041, 2'd0, 1'b1);
    push_word(32'h0000_4342, 2'd1, 1'b1);
    wr_en = 1'b0;
    wait_idle(600, ok);
    n_vec++;
    if (!ok || n_pulse - base != 3 || exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL b2b: idle=%b pulses=%0d left=%0d, required 1 3 0",
               idle, n_pulse - base, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    int base;
    stall = 1'b1;
    push_word(32'h0000_005A, 2'd0, 1'b1);
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    base = n_pulse;
    for (int i = 0; i < 16; i++) begin
      push_word(32'h10 + i, 2'd0, 1'b1);
      if (i == 14) begin
        n_vec++;
        if (full !== 1'b0) begin
          n_miss++;
          $display("FAIL full_early: full=%b after 15 pushes, required 0", full);
        end
      end
    end
    n_vec++;
    if (full !== 1'b1) begin
      n_miss++;
      $display("FAIL full_16: full=%b after 16 pushes, required 1", full);
    end
    push_word(32'h0000_00FF, 2'd0, 1'b0);
    wr_en = 1'b0;
    n_vec++;
    if (full !== 1'b1 || n_pulse != base) begin
      n_miss++;
      $display("FAIL stall_hold: full=%b pulses=%0d, required 1 %0d", full, n_pulse, base);
    end
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    n_vec++;
    if (ovf_cnt !== 16'h0001) begin
      n_miss++;
      $display("FAIL ovf_one: ovf_cnt=%h, required 0001", ovf_cnt);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_vec++;
    if (ovf_cnt !== 16'h0000) begin
      n_miss++;
      $display("FAIL ovf_clr: ovf_cnt=%h, required 0000", ovf_cnt);
    end
`endif
  endtask

  task automatic test_pop_collision();
    int drops = 0;
    bit ok;
    stall = 1'b0;
    for (int i = 0; i < 10 && m_busy !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < FRAME_CYC + 10 && m_busy !== 1'b0; i++) @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (full === 1'b0) begin
        ok = 1'b1;
        break;
      end
      wr_en   = 1'b1;
      wr_data = 32'h0000_00EE;
      wr_len  = 2'd0;
      drops++;
      @(negedge clk);
    end
    wr_en = 1'b0;
    n_vec++;
    if (!ok || drops < 1) begin
      n_miss++;
      $display("FAIL collision_pop: full_cleared=%b drops=%0d, required 1 >=1", ok, drops);
    end
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    n_vec++;
    if (ovf_cnt !== 16'(drops)) begin
      n_miss++;
      $display("FAIL collision_ovf: ovf_cnt=%0d, required %0d", ovf_cnt, drops);
    end
`endif
    push_word(32'h0000_0077, 2'd0, 1'b1);
    wr_en = 1'b0;
    n_vec++;
    if (full !== 1'b1) begin
      n_miss++;
      $display("FAIL collision_count: full=%b after one push onto 15, required 1", full);
    end
    wait_idle(3000, ok);
    n_vec++;
    if (!ok || exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: idle=%b left=%0d, required 1 0", idle, exp_q.size());
    end
  endtask

  task automatic test_reset_midword();
    int base = n_pulse;
    push_word(32'h4433_2211, 2'd3, 1'b1);
    wr_en = 1'b0;
    for (int i = 0; i < 500 && n_pulse < base + 2; i++) @(negedge clk);
    for (int i = 0; i < 10 && m_busy !== 1'b1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_vec++;
    if (n_pulse - base != 2 || m_busy !== 1'b1) begin
      n_miss++;
      $display("FAIL midword_setup: pulses=%0d busy=%b, required 2 1", n_pulse - base, m_busy);
    end
    rstn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    n_vec++;
    if (tx_start !== 1'b0 || idle !== 1'b1 || full !== 1'b0 || sdata !== 8'h00) begin
      n_miss++;
      $display("FAIL midword_reset: tx_start=%b idle=%b full=%b sdata=%h, required 0 1 0 00",
               tx_start, idle, full, sdata);
    end
    base = n_pulse;
    repeat (200) @(negedge clk);
    n_vec++;
    if (n_pulse != base || idle !== 1'b1) begin
      n_miss++;
      $display("FAIL midword_quiet: pulses=%0d idle=%b, required 0 1", n_pulse - base, idle);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_pop_collision();
    test_reset_midword();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
